// File: rtl/slot_event_queue.sv
// slot_event_queue: debounces a bank of parking-slot switches and queues one
// enter/exit event per debounced change, lowest slot index first, into a
// small FIFO with a valid/ready consumer interface. Also tracks occupancy.
module slot_event_queue #(
  parameter int N_SLOTS      = 16,
  parameter int DEBOUNCE_CYC = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SLOTS-1:0]           SW,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [$clog2(N_SLOTS)-1:0]   ev_slot,
  output logic                         ev_enter,
  output logic [$clog2(N_SLOTS+1)-1:0] occ_cnt,
  output logic                         lot_full,
  output logic                         q_full
);

  localparam int SLOT_W = $clog2(N_SLOTS);
  localparam int OCC_W  = $clog2(N_SLOTS + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYC) + 1;
  localparam int EV_W   = SLOT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  // Number of set bits in a slot vector.
  function automatic logic [OCC_W-1:0] f_popcount(input logic [N_SLOTS-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      c = c + {{(OCC_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [N_SLOTS-1:0]             r_sync1;
  logic [N_SLOTS-1:0]             r_sw_s;
  logic [N_SLOTS-1:0]             r_stable;
  logic [N_SLOTS-1:0][CNT_W-1:0]  r_cnt;
  logic [N_SLOTS-1:0]             r_pending;
  logic [EV_W-1:0]                r_mem [FIFO_DEPTH];
  logic [AW:0]                    r_wr_ptr;
  logic [AW:0]                    r_rd_ptr;
  logic [OCC_W-1:0]               r_occ_cnt;
  logic                           r_lot_full;

  logic [N_SLOTS-1:0]             w_flip;
  logic [N_SLOTS-1:0][CNT_W-1:0]  w_cnt_nxt;
  logic [SLOT_W-1:0]              w_sel;
  logic                           w_has_pending;
  logic                           w_empty;
  logic                           w_full;
  logic                           w_pop;
  logic                           w_push;
  logic [N_SLOTS-1:0]             w_push_mask;
  logic [N_SLOTS-1:0]             w_pending_nxt;
  logic [EV_W-1:0]                w_push_data;
  logic [EV_W-1:0]                w_head;

  // Two-flop synchronizer on every raw switch bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sw_s  <= '0;
    end else begin
      r_sync1 <= SW;
      r_sw_s  <= r_sync1;
    end
  end

  // Per-slot debounce: count consecutive disagreeing samples, flip when the run is long enough.
  always_comb begin
    w_flip    = '0;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (r_sw_s[i] == r_stable[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_flip[i]    = 1'b1;
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Lowest-index pending slot; scanning downward leaves the smallest index last.
  always_comb begin
    w_sel         = '0;
    w_has_pending = |r_pending;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel = SLOT_W'(i);
      end else begin
        w_sel = w_sel;
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && ev_ready;
  assign w_push  = w_has_pending && (!w_full || w_pop);

  // A pushed slot leaves the pending set; a flip toggles it, so a flip on the
  // push edge re-arms the slot and a flip back before dispatch cancels it.
  always_comb begin
    w_push_mask   = '0;
    w_push_data   = {r_stable[w_sel], w_sel};
    if (w_push) begin
      w_push_mask = {{(N_SLOTS-1){1'b0}}, 1'b1} << w_sel;
    end else begin
      w_push_mask = '0;
    end
    w_pending_nxt = (r_pending & ~w_push_mask) ^ w_flip;
  end

  // Debounced state, counters, pending mask and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable   <= '0;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_occ_cnt  <= '0;
      r_lot_full <= 1'b0;
    end else begin
      r_stable   <= r_stable ^ w_flip;
      r_cnt      <= w_cnt_nxt;
      r_pending  <= w_pending_nxt;
      r_occ_cnt  <= f_popcount(r_stable);
      r_lot_full <= (f_popcount(r_stable) == OCC_W'(N_SLOTS));
    end
  end

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
    end
  end

  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign ev_valid = !w_empty;
  assign ev_slot  = w_empty ? '0 : w_head[SLOT_W-1:0];
  assign ev_enter = w_empty ? 1'b0 : w_head[SLOT_W];
  assign occ_cnt  = r_occ_cnt;
  assign lot_full = r_lot_full;
  assign q_full   = w_full;

endmodule

// File: tb/tb_slot_event_queue.sv
// Bench for slot_event_queue: a behavioural model predicts each event into a
// scoreboard queue; a monitor compares the DUT head against it on every cycle.
module tb_slot_event_queue;

  localparam int NS  = 16;
  localparam int DEB = 4;
  localparam int FD  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] SW;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_slot;
  logic        ev_enter;
  logic [4:0]  occ_cnt;
  logic        lot_full;
  logic        q_full;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: switch history window per slot, debounced set, pending set,
  // modelled queue occupancy and registered occupancy count.
  logic [15:0]    m_sync1   = '0;
  logic [15:0]    m_sws     = '0;
  logic [15:0]    m_stable  = '0;
  logic [15:0]    m_pending = '0;
  logic [DEB-1:0] m_hist [NS];
  int             m_cnt = 0;
  int             m_occ = 0;
  logic [4:0]     exp_q [$];
  logic [4:0]     got_q [$];

  slot_event_queue #(.N_SLOTS(NS), .DEBOUNCE_CYC(DEB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .SW(SW), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_slot(ev_slot), .ev_enter(ev_enter), .occ_cnt(occ_cnt),
    .lot_full(lot_full), .q_full(q_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, ev_valid, 0);
    check({tag, "_slot"}, ev_slot, 0);
    check({tag, "_enter"}, ev_enter, 0);
    check({tag, "_occ"}, occ_cnt, 0);
    check({tag, "_lot_full"}, lot_full, 0);
    check({tag, "_q_full"}, q_full, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    got_q.delete();
  endtask

  // Reference model: a slot changes once its last DEB synchronized samples all
  // disagree with its debounced value; a change toggles membership of the
  // pending set; each cycle the smallest pending slot moves to the queue when
  // there is room (counting the entry leaving the same cycle).
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (rst !== 1'b1) begin
        m_sync1 = '0; m_sws = '0; m_stable = '0; m_pending = '0;
        m_cnt = 0; m_occ = 0;
        for (int i = 0; i < NS; i++) m_hist[i] = '0;
        exp_q.delete();
      end else begin
        logic [15:0] flips;
        int          sel;
        bit          pop;
        bit          push;
        pop   = (m_cnt > 0) && (ev_ready === 1'b1);
        flips = '0;
        for (int i = 0; i < NS; i++) begin
          m_hist[i] = {m_hist[i][DEB-2:0], m_sws[i]};
          if (m_hist[i] == {DEB{~m_stable[i]}}) flips[i] = 1'b1;
        end
        sel = -1;
        for (int i = 0; i < NS; i++) begin
          if (sel < 0 && m_pending[i]) sel = i;
        end
        push = (sel >= 0) && ((m_cnt < FD) || pop);
        if (push) begin
          exp_q.push_back({m_stable[sel], 4'(sel)});
          m_pending[sel] = 1'b0;
        end
        m_pending = m_pending ^ flips;
        m_cnt     = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        m_occ     = $countones(m_stable);
        m_stable  = m_stable ^ flips;
        m_sws     = m_sync1;
        m_sync1   = SW;
      end
    end
  end

  // Monitor: compare flags every cycle and the head whenever the DUT offers one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        check("ev_valid", ev_valid, m_cnt > 0);
        check("q_full", q_full, m_cnt == FD);
        check("occ_cnt", occ_cnt, m_occ);
        check("lot_full", lot_full, m_occ == NS);
        if (ev_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ev_head: got %0h expected no event at %0t", {ev_enter, ev_slot}, $time);
          end else begin
            check("ev_head", {ev_enter, ev_slot}, exp_q[0]);
            if (ev_ready === 1'b1) begin
              got_q.push_back({ev_enter, ev_slot});
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int lat;
    int n3;
    rst = 1'b0; SW = '0; ev_ready = 1'b0;
    tick(3);
    check_zero("init");
    rst = 1'b1;
    tick(2);

    // Single enter: event latency counted from the first edge seeing SW.
    ev_ready = 1'b1;
    SW = 16'h0004;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (ev_valid === 1'b1 && lat == 0) lat = k;
      if (lat != 0) break;
    end
    check("enter_latency", lat, 7);
    check("enter_slot", ev_slot, 2);
    check("enter_dir", ev_enter, 1);
    check("enter_occ", occ_cnt, 1);
    tick(1);
    check("enter_one_cycle", ev_valid, 0);

    // Glitch shorter than the debounce window.
    got_q.delete();
    SW[5] = 1'b1;
    tick(3);
    SW[5] = 1'b0;
    tick(20);
    check("glitch_events", got_q.size(), 0);
    check("glitch_occ", occ_cnt, 1);

    // Simultaneous enters come out in ascending order.
    SW = '0;
    do_reset();
    ev_ready = 1'b1;
    SW = 16'h8101;
    tick(20);
    check("simul_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("simul_ev0", got_q[0], 5'h10);
      check("simul_ev1", got_q[1], 5'h18);
      check("simul_ev2", got_q[2], 5'h1F);
    end
    check("simul_occ", occ_cnt, 3);

    // Backpressure: 12 enters with the consumer stalled.
    SW = '0;
    do_reset();
    ev_ready = 1'b0;
    SW = 16'h0FFF;
    tick(20);
    check("bp_q_full", q_full, 1);
    check("bp_occ", occ_cnt, 12);
    ev_ready = 1'b1;
    tick(30);
    check("bp_count", got_q.size(), 12);
    for (int k = 0; k < 12 && k < got_q.size(); k++) begin
      check("bp_order", got_q[k], {1'b1, 4'(k)});
    end

    // Cancel: slot 3 enters and leaves while the queue is full.
    SW = '0;
    do_reset();
    ev_ready = 1'b0;
    SW = 16'h0FF0;
    tick(20);
    check("cancel_q_full", q_full, 1);
    SW = 16'h0FF8;
    tick(12);
    SW = 16'h0FF0;
    tick(12);
    ev_ready = 1'b1;
    tick(30);
    check("cancel_count", got_q.size(), 8);
    n3 = 0;
    foreach (got_q[k]) if (got_q[k][3:0] == 4'd3) n3++;
    check("cancel_slot3", n3, 0);
    check("cancel_occ", occ_cnt, 8);

    // Full lot, then reset in the middle of draining exits.
    SW = '0;
    do_reset();
    ev_ready = 1'b1;
    SW = 16'hFFFF;
    tick(40);
    check("full_lot", lot_full, 1);
    check("full_occ", occ_cnt, 16);
    check("full_count", got_q.size(), 16);
    ev_ready = 1'b0;
    SW = '0;
    tick(20);
    ev_ready = 1'b1;
    tick(2);
    check("drain_active", ev_valid, 1);
    SW = 16'hFFFF;
    do_reset();
    tick(40);
    check("reenter_count", got_q.size(), 16);
    check("reenter_occ", occ_cnt, 16);

    // Random switch activity with varying consumer pressure.
    SW = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      int b;
      ev_ready = ($urandom_range(0, 99) < ((c < 1500) ? 75 : 25));
      r = $urandom_range(0, 7);
      if (r == 0) begin
        SW[$urandom_range(0, 15)] ^= 1'b1;
      end else if (r == 1) begin
        b = $urandom_range(0, 15);
        SW[b] ^= 1'b1;
        tick($urandom_range(1, 3));
        SW[b] ^= 1'b1;
      end
      tick(1);
    end
    ev_ready = 1'b1;
    tick(100);
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle", ev_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
